// File: rtl/fp_mult_stream.sv
// Streaming wrapper around a fixed-latency, no-stall FP multiplier: credit-based
// operand issue, a result FIFO drained by valid/ready, and saturating flag statistics.
module fp_mult_stream #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_a,
  input  logic [31:0]                  in_b,
  output logic                         mul_reset,
  output logic [31:0]                  mul_a,
  output logic [31:0]                  mul_b,
  input  logic [31:0]                  mul_result,
  input  logic                         mul_exception,
  input  logic                         mul_overflow,
  input  logic                         mul_underflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_result,
  output logic [2:0]                   out_flags,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                  exc_count,
  output logic [15:0]                  ovf_count,
  output logic [15:0]                  unf_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [LATENCY-1:0] vpipe;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [IW-1:0]      inflight;
  logic [SW-1:0]      reserved;
  logic               issue;
  logic               wr_en;
  logic               deq;
  logic [31:0]        res_mem  [DEPTH];
  logic [2:0]         flag_mem [DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + IW'(vpipe[i]);
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and in_ready never depends on out_ready.
  // Every slot that is queued or still inside the multiplier holds a credit, so a
  // result arriving from the multiplier always finds room in the FIFO.
  assign reserved  = SW'(count) + SW'(inflight);
  assign in_ready  = reset_n & (reserved < SW'(DEPTH));
  assign issue     = in_valid & in_ready;
  assign wr_en     = vpipe[LATENCY-1];
  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready;
  assign occupancy = CW'(reserved);

  assign mul_reset = ~reset_n;
  assign mul_a     = in_a;
  assign mul_b     = in_b;

  // Head fields read as zero while empty, so the array itself needs no reset.
  assign out_result = out_valid ? res_mem[rd_ptr]  : 32'h0;
  assign out_flags  = out_valid ? flag_mem[rd_ptr] : 3'b000;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      res_mem[wr_ptr]  <= mul_result;
      flag_mem[wr_ptr] <= {mul_exception, mul_overflow, mul_underflow};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe     <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      exc_count <= '0;
      ovf_count <= '0;
      unf_count <= '0;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (deq)   rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (deq && out_flags[2] && exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
      if (deq && out_flags[1] && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      if (deq && out_flags[0] && unf_count != 16'hFFFF) unf_count <= unf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_mult_stream.sv
// Bench for fp_mult_stream: a stand-in 3-stage multiplier, a negedge monitor with a
// result scoreboard, a directed vector table, and hand-written multi-cycle sequences.
module tb_fp_mult_stream;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mul_reset;
  logic [31:0] mul_a, mul_b, mul_result;
  logic        mul_exception, mul_overflow, mul_underflow;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [2:0]  occupancy;
  logic [15:0] exc_count, ovf_count, unf_count;

  always #5 clk = ~clk;

  fp_mult_stream #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_reset(mul_reset), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_exception(mul_exception), .mul_overflow(mul_overflow),
    .mul_underflow(mul_underflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .occupancy(occupancy),
    .exc_count(exc_count), .ovf_count(ovf_count), .unf_count(unf_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Truncating single-precision multiply; returns {result, exception, overflow, underflow}.
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {32'h0, 3'b100};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0, 3'b000};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 3'b010};
    if (e <= 0) return {32'h0, 3'b001};
    return {s, e[7:0], m, 3'b000};
  endfunction

  // Stand-in multiplier: operands sampled at edge T, result register updated at T+2.
  logic [34:0] p1, p2, pr;
  always_ff @(posedge clk or posedge mul_reset) begin
    if (mul_reset) begin
      p1 <= '0;
      p2 <= '0;
      pr <= '0;
    end else begin
      p1 <= fmul(mul_a, mul_b);
      p2 <= p1;
      pr <= p2;
    end
  end
  assign mul_result = pr[34:3];
  assign {mul_exception, mul_overflow, mul_underflow} = pr[2:0];

  // Scoreboard and occupancy model
  logic [34:0]        exp_q[$];
  logic [31:0]        deq_log[$];
  logic [LATENCY-1:0] m_pipe = '0;
  int                 m_count = 0;
  logic [15:0]        m_exc = '0, m_ovf = '0, m_unf = '0;

  task automatic clear_model();
    exp_q.delete();
    m_pipe  = '0;
    m_count = 0;
    m_exc   = '0;
    m_ovf   = '0;
    m_unf   = '0;
  endtask

  always @(negedge clk) begin
    logic [34:0] e;
    int          pend;
    logic        wr;
    logic        dq;
    chk("mul_reset", mul_reset, !reset_n);
    if (!reset_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_flags", out_flags, 0);
      chk("rst_counts", {exc_count, ovf_count, unf_count}, 0);
    end else begin
      pend = m_count + $countones(m_pipe);
      chk("out_valid", out_valid, m_count != 0);
      chk("occupancy", occupancy, pend);
      chk("in_ready", in_ready, pend < DEPTH);
      chk("exc_count", exc_count, m_exc);
      chk("ovf_count", ovf_count, m_ovf);
      chk("unf_count", unf_count, m_unf);
      dq = out_valid && out_ready;
      if (dq) begin
        if (exp_q.size() == 0) begin
          chk("deq_without_expected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", out_result, e[34:3]);
          chk("out_flags", out_flags, e[2:0]);
          if (e[2] && m_exc != 16'hFFFF) m_exc = m_exc + 16'd1;
          if (e[1] && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
          if (e[0] && m_unf != 16'hFFFF) m_unf = m_unf + 16'd1;
        end
        deq_log.push_back(out_result);
      end
      if (in_valid && in_ready) exp_q.push_back(fmul(in_a, in_b));
      wr = m_pipe[LATENCY-1];
      if (wr) chk("write_finds_room", m_count < DEPTH, 1);
      m_count = m_count + int'(wr) - int'(dq && m_count > 0);
      m_pipe  = {m_pipe[LATENCY-2:0], in_valid && in_ready};
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] kval[8];
  logic        acc;
  int          k;
  int          n;

  initial begin
    vecs[0] = '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
    vecs[1] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
    vecs[2] = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001};
    vecs[3] = '{32'h7F800000, 32'h3F800000, 32'h00000000, 3'b100};
    vecs[4] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
    vecs[5] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000};
    kval = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    // Power-on reset
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = vecs[i].a;
      in_b = vecs[i].b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_latency_c%0d", i, c), out_valid, c == 3);
      end
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), out_flags, vecs[i].flags);
      if (i == 0) chk("vec0_no_count_change", {exc_count, ovf_count, unf_count}, 0);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
    @(negedge clk);
    chk("table_exc_count", exc_count, 1);
    chk("table_ovf_count", ovf_count, 1);
    chk("table_unf_count", unf_count, 1);

    // Backpressure: 1.0 x k with the consumer stalled
    deq_log.delete();
    @(posedge clk); #1;
    k = 0;
    in_valid = 1'b1;
    in_a = 32'h3F800000;
    in_b = kval[0];
    repeat (12) begin
      @(negedge clk) acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 8) in_b = kval[k]; else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", k, 4);
    @(negedge clk);
    chk("bp_occupancy", occupancy, 4);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int c = 0; c < 80 && !(k == 8 && deq_log.size() == 8); c++) begin
      @(negedge clk) acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 8) in_b = kval[k]; else in_valid = 1'b0;
      end
    end
    chk("bp_total_dequeued", deq_log.size(), 8);
    for (int i = 0; i < 8 && i < deq_log.size(); i++)
      chk($sformatf("bp_order_%0d", i), deq_log[i], kval[i]);

    // Random streaming with a random consumer
    deq_log.delete();
    n = 0;
    in_valid = 1'b1;
    in_a = $urandom();
    in_b = $urandom();
    for (int c = 0; c < 3000 && n < 100; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk) acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        in_a = $urandom();
        in_b = $urandom();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && deq_log.size() < 100; c++) @(posedge clk);
    #1;
    chk("stream_issued", n, 100);
    chk("stream_dequeued", deq_log.size(), 100);
    chk("stream_queue_empty", exp_q.size(), 0);

    // Reset while three results are still inside the multiplier
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h40000000;
    in_b = 32'h40400000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    clear_model();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_counts", {exc_count, ovf_count, unf_count}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_stale_%0d", c), out_valid, 0);
    end

    // Saturation of the exception counter
    @(posedge clk); #1;
    n = 0;
    in_valid = 1'b1;
    in_a = 32'h7F800000;
    in_b = 32'h3F800000;
    for (int c = 0; c < 90000 && n < 65540; c++) begin
      @(negedge clk) acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) n++;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("sat_issued", n, 65540);
    chk("sat_exc_count", exc_count, 16'hFFFF);
    chk("sat_ovf_count", ovf_count, 0);
    chk("sat_unf_count", unf_count, 0);
    chk("sat_drained", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
